// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Architectural register file for the LEGv8 datapath. It holds 2**ADDR_BITS
//   registers of WIDTH bits. It has two combinational read ports and one write
//   port that updates on the rising clock edge. Register ZERO_REG (XZR) always
//   reads 0, and writes to it are discarded.
//
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   -> a write in flight is forwarded to BusA/BusB in the same
//                  cycle when the read address matches RW.
//     undefined -> reads always return the stored contents.
//
// Ports
//   Clk    in   1          system clock, rising edge
//   Reset  in   1          synchronous active-high reset, clears all registers
//   RA     in   ADDR_BITS  read address, port A
//   RB     in   ADDR_BITS  read address, port B
//   RW     in   ADDR_BITS  write address
//   BusW   in   WIDTH      write data
//   RegWr  in   1          write enable
//   BusA   out  WIDTH      read data, port A
//   BusB   out  WIDTH      read data, port B
// -----------------------------------------------------------------------------
module register_file #(
   parameter int WIDTH     = 64,
   parameter int ADDR_BITS = 5,
   parameter int ZERO_REG  = 31
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [ADDR_BITS-1:0] RA,
   input  logic [ADDR_BITS-1:0] RB,
   input  logic [ADDR_BITS-1:0] RW,
   input  logic [WIDTH-1:0]     BusW,
   input  logic                 RegWr,
   output logic [WIDTH-1:0]     BusA,
   output logic [WIDTH-1:0]     BusB
);

   localparam int                   Depth    = 2 ** ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] zeroAddr = ADDR_BITS'(ZERO_REG);

   logic [WIDTH-1:0] regs [Depth];
   logic             writeEn;

   // Writes aimed at XZR are dropped here, so every other path can treat
   // writeEn as the single authority on whether a write really happens.
   assign writeEn = RegWr && (RW != zeroAddr);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < Depth; i++) begin
            regs[i] <= '0;
         end
      end else if (writeEn) begin
         regs[RW] <= BusW;
      end
   end

   // Read ports. XZR is masked on the read side as well, so it stays zero
   // even though its storage slot exists in the array.
   always_comb begin
      BusA = (RA == zeroAddr) ? '0 : regs[RA];
      BusB = (RB == zeroAddr) ? '0 : regs[RB];
`ifdef REGFILE_BYPASS_EN
      // writeEn already excludes RW == XZR, so a match cannot forward
      // a value into a zero-register read.
      if (writeEn && !Reset && (RA == RW)) begin
         BusA = BusW;
      end
      if (writeEn && !Reset && (RB == RW)) begin
         BusB = BusW;
      end
`endif
   end

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;

   localparam int WIDTH     = 64;
   localparam int ADDR_BITS = 5;

   logic                 Clk = 1'b0;
   logic                 Reset;
   logic [ADDR_BITS-1:0] RA, RB, RW;
   logic [WIDTH-1:0]     BusW;
   logic                 RegWr;
   logic [WIDTH-1:0]     BusA, BusB;

   register_file #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS), .ZERO_REG(31)) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .RA   (RA),
      .RB   (RB),
      .RW   (RW),
      .BusW (BusW),
      .RegWr(RegWr),
      .BusA (BusA),
      .BusB (BusB)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int               id;
      logic [WIDTH-1:0] expA;
      logic [WIDTH-1:0] expB;
   } expT;

   expT expQ[$];
   int  checks   = 0;
   int  failures = 0;
   int  nextId   = 0;
   bit  doneStim = 1'b0;

`ifdef REGFILE_BYPASS_EN
   localparam bit bypass = 1'b1;
`else
   localparam bit bypass = 1'b0;
`endif

   // Monitor: the read ports are combinational, so the response to whatever
   // the stimulus drove after the rising edge is sampled at the falling edge.
   always @(negedge Clk) begin
      if (expQ.size() > 0) begin
         expT e;
         e = expQ.pop_front();
         checks++;
         if (BusA !== e.expA) begin
            failures++;
            $display("FAIL read%0d BusA: got %h expected %h (RA=%0d)", e.id, BusA, e.expA, RA);
         end
         checks++;
         if (BusB !== e.expB) begin
            failures++;
            $display("FAIL read%0d BusB: got %h expected %h (RB=%0d)", e.id, BusB, e.expB, RB);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Drive the read addresses and queue the expected outputs for this cycle.
   task automatic readCheck(input int ra, input int rb,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      expT e;
      RA     = ADDR_BITS'(ra);
      RB     = ADDR_BITS'(rb);
      e.id   = nextId++;
      e.expA = a;
      e.expB = b;
      expQ.push_back(e);
      tick();
   endtask

   task automatic writeReg(input int rw, input logic [WIDTH-1:0] d);
      RW    = ADDR_BITS'(rw);
      BusW  = d;
      RegWr = 1'b1;
      tick();
      RegWr = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; RegWr = 1'b0; RA = '0; RB = '0; RW = '0; BusW = '0;
      tick();
      Reset = 1'b0;

      // Every register reads zero after reset.
      for (int i = 0; i < 32; i++) readCheck(i, 31 - i, 64'd0, 64'd0);

      // Basic write then read on both ports.
      writeReg(5, 64'h0123_4567_89AB_CDEF);
      readCheck(5, 5, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

      // A write to XZR reads zero in the same cycle and afterwards.
      RW = 5'd31; BusW = '1; RegWr = 1'b1;
      readCheck(31, 31, 64'd0, 64'd0);
      RegWr = 1'b0;
      readCheck(31, 31, 64'd0, 64'd0);

      // With RegWr low, the register does not change.
      RW = 5'd3; BusW = 64'd7; RegWr = 1'b0;
      tick();
      readCheck(3, 3, 64'd0, 64'd0);

      // Fill registers 0 to 30 with i*3 and read them in crossed order.
      for (int i = 0; i <= 30; i++) writeReg(i, 64'(i * 3));
      for (int i = 0; i <= 30; i++) readCheck(i, 30 - i, 64'(i * 3), 64'((30 - i) * 3));

      // Reset and write in the same cycle: reset wins. No forwarding happens
      // while Reset is high, so the old contents are still visible.
      Reset = 1'b1; RegWr = 1'b1; RW = 5'd7; BusW = 64'd99;
      readCheck(7, 8, 64'd21, 64'd24);
      Reset = 1'b0; RegWr = 1'b0;
      readCheck(7, 30, 64'd0, 64'd0);
      writeReg(7, 64'd99);
      readCheck(7, 7, 64'd99, 64'd99);

      // Read during a write to the same address.
      writeReg(9, 64'd1);
      RW = 5'd9; BusW = 64'd2; RegWr = 1'b1;
      readCheck(9, 9, bypass ? 64'd2 : 64'd1, bypass ? 64'd2 : 64'd1);
      RegWr = 1'b0;
      readCheck(9, 9, 64'd2, 64'd2);

      // Only port B matches the write address.
      writeReg(11, 64'hAA);
      RW = 5'd11; BusW = 64'hBB; RegWr = 1'b1;
      readCheck(7, 11, 64'd99, bypass ? 64'hBB : 64'hAA);
      RegWr = 1'b0;

      // For back-to-back writes, the last one wins; the top bit is preserved.
      writeReg(10, 64'h1111);
      writeReg(10, 64'h8000_0000_0000_0001);
      readCheck(10, 11, 64'h8000_0000_0000_0001, 64'hBB);

      tick();
      tick();
      doneStim = 1'b1;
   end

   initial begin
      fork
         wait (doneStim);
         #100000;
      join_any
      disable fork;
      checks++;
      if (!doneStim) begin
         failures++;
         $display("FAIL timeout: stimulus done=%0d required 1", doneStim);
      end
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file for the LEGv8 datapath: 32 x 64-bit registers, two combinational read ports and one synchronous write port.
- Read ports BusA/BusB feed the operand-select 2:1 muxes (ALU source, memory write data) directly downstream.
- Write port is driven by the write-back mux output.
- Register X31 (XZR) is hardwired to zero.

Parameters:
- WIDTH, 64, data width of each register and bus.
- ADDR_BITS, 5, register address width; depth = 2**ADDR_BITS.
- ZERO_REG, 31, index that always reads 0 and ignores writes.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
- RA  input  ADDR_BITS  read address, port A.
- RB  input  ADDR_BITS  read address, port B.
- RW  input  ADDR_BITS  write address.
- BusW  input  WIDTH  write data.
- RegWr  input  1  write enable.
- BusA  output  WIDTH  read data, port A.
- BusB  output  WIDTH  read data, port B.

Behaviour:
- One clock; reset is synchronous and active-high.
  - Reset is sampled only at rising Clk.
  - Reset high at an edge clears all registers to 0 on that edge.
- Storage:
  - 2**ADDR_BITS registers of WIDTH bits.
  - No state machine; the register array is the only state.
- Write:
  - At rising Clk with Reset=0, RegWr=1 and RW!=ZERO_REG: reg[RW] <= BusW.
  - The new value is visible on the read ports immediately after that edge.
- Write suppression:
  - RegWr=0: no register changes.
  - RW==ZERO_REG: write discarded, regardless of RegWr.
- Read:
  - Fully combinational, zero-cycle latency: BusA = reg[RA], BusB = reg[RB].
  - Any read of ZERO_REG returns 0.
  - RA and RB are independent and may be equal.
- Reset values:
  - After a reset edge, every register is 0, so BusA = BusB = 0 for all addresses.
  - Before the first reset edge, register contents are undefined.
- Reset and write in the same cycle: reset wins; the write is dropped.
- Reset mid-operation: discards all prior contents. The first write is accepted on the first edge with Reset=0.
- Read-during-write, same address, without bypass: the read port returns the old value until the edge, then the new value.
- Back-to-back writes to the same RW on consecutive edges: the last write wins. No hazard tracking is done here.
- Width rule: BusW is stored unmodified. No sign extension or truncation.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If RegWr=1, Reset=0, RW!=ZERO_REG and RA==RW, then BusA = BusW combinationally in the same cycle.
  - The same rule applies to RB/BusB.
  - Reads of ZERO_REG still return 0.
- Undefined: no forwarding. Reads always return stored contents (old value before the edge).

Test Plan:
- Reset=1 for one edge, then read RA=0..31 and RB=31..0 -> BusA=BusB=0 for every address.
- Write BusW=64'h0123_4567_89AB_CDEF to RW=5 with RegWr=1. Next cycle RA=5, RB=5 -> BusA=BusB=64'h0123_4567_89AB_CDEF.
- Write 64'hFFFF_FFFF_FFFF_FFFF to RW=31 with RegWr=1, then RA=31 -> BusA=0. Write 64'd7 to RW=3 with RegWr=0 -> reg[3] unchanged (reads 0 after reset).
- Fill regs 0..30 with value i*3, then read RA=i, RB=30-i for all i -> BusA=i*3, BusB=(30-i)*3. No aliasing.
- Same cycle: Reset=1, RegWr=1, RW=7, BusW=64'd99 -> after the edge, reg[7]=0. Following cycle with Reset=0, write 64'd99 -> reg[7]=99.
- reg[9]=64'd1; in the cycle RegWr=1, RW=9, BusW=64'd2, read RA=9 before the edge -> BusA=1 without REGFILE_BYPASS_EN, BusA=2 with it. After the edge, BusA=2 in both builds.
